// File: rtl/ov7670_config_seq.sv
// OV7670 SCCB configuration sequencer: walks a (register, value) table
// and issues each entry as a 3-byte write through the byte-level I2C engine.
`timescale 1ns/1ps
module ov7670_config_seq #(
    parameter int unsigned POWERUP_TICKS = 6000000,
    parameter int unsigned GAP_TICKS     = 10,
    parameter int unsigned TIMEOUT_TICKS = 50000,
    parameter int unsigned DELAY_UNIT    = 50000,
    parameter int unsigned ADDR_W        = 6,
    parameter logic [7:0]  SLAVE_WADDR   = 8'h42
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic [ADDR_W-1:0] tbl_addr,
    input  logic [15:0]       tbl_data,
    output logic              i2c_strobe,
    output logic [7:0]        i2c_data,
    output logic              i2c_last,
    input  logic              i2c_busy,
    output logic              cfg_busy,
    output logic              cfg_done,
    output logic              cfg_error,
    output logic [ADDR_W:0]   write_count
);

    localparam logic [2:0] S_POWERUP = 3'd0;
    localparam logic [2:0] S_FETCH   = 3'd1;
    localparam logic [2:0] S_SEND    = 3'd2;
    localparam logic [2:0] S_WAIT    = 3'd3;
    localparam logic [2:0] S_GAP     = 3'd4;
    localparam logic [2:0] S_DELAY   = 3'd5;
    localparam logic [2:0] S_DONE    = 3'd6;
    localparam logic [2:0] S_ERROR   = 3'd7;

    // One shared down/up counter serves power-up, gap, delay and timeout.
    localparam int unsigned DELAY_MAX = 255 * DELAY_UNIT;
    localparam int unsigned M1 = (POWERUP_TICKS > DELAY_MAX) ? POWERUP_TICKS : DELAY_MAX;
    localparam int unsigned M2 = (TIMEOUT_TICKS > GAP_TICKS) ? TIMEOUT_TICKS : GAP_TICKS;
    localparam int unsigned CNT_MAX = (M1 > M2) ? M1 : M2;
    localparam int unsigned CNT_W = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] PWR_LD = CNT_W'(POWERUP_TICKS);
    localparam logic [CNT_W-1:0] GAP_LD =
        CNT_W'((GAP_TICKS == 0) ? 0 : GAP_TICKS - 1);
    localparam logic [CNT_W-1:0] TO_LAST =
        CNT_W'((TIMEOUT_TICKS == 0) ? 0 : TIMEOUT_TICKS - 1);
    localparam logic [CNT_W-1:0] DU_C = CNT_W'(DELAY_UNIT);

    localparam logic [15:0]       END_MARK  = 16'hFFFF;
    localparam logic [7:0]        DELAY_REG = 8'hF0;
    localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

    logic [2:0]       state;
    logic [CNT_W-1:0] cnt;
    logic             guard;
    logic [1:0]       k;
    logic [7:0]       reg_b;
    logic [7:0]       val_b;
    logic [CNT_W-1:0] delay_ticks;
    logic             is_delay;
    logic             is_end;

    assign delay_ticks = CNT_W'(tbl_data[7:0]) * DU_C;
    assign is_end      = (tbl_data == END_MARK);
    assign is_delay    = (tbl_data[15:8] == DELAY_REG);

    assign i2c_strobe = (state == S_SEND);
    assign cfg_done   = (state == S_DONE);
    assign cfg_error  = (state == S_ERROR);
    assign cfg_busy   = !(cfg_done || cfg_error);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_POWERUP;
            cnt         <= PWR_LD;
            guard       <= 1'b0;
            k           <= 2'd0;
            reg_b       <= 8'h00;
            val_b       <= 8'h00;
            tbl_addr    <= '0;
            i2c_data    <= 8'h00;
            i2c_last    <= 1'b0;
            write_count <= '0;
        end else begin
            unique case (state)
                S_POWERUP: begin
                    if (cnt == '0) begin
                        state <= S_FETCH;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_FETCH: begin
                    if (is_end) begin
                        state <= S_DONE;
                    end else if (is_delay) begin
                        cnt   <= (tbl_data[7:0] == 8'h00) ? '0 : delay_ticks - 1'b1;
                        state <= S_DELAY;
                    end else begin
                        reg_b    <= tbl_data[15:8];
                        val_b    <= tbl_data[7:0];
                        k        <= 2'd0;
                        i2c_data <= SLAVE_WADDR;
                        i2c_last <= 1'b0;
                        state    <= S_SEND;
                    end
                end
                S_SEND: begin
                    guard <= 1'b1;
                    cnt   <= '0;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    // Engine may not raise busy until after the strobe cycle.
                    if (guard) begin
                        guard <= 1'b0;
                    end else if (!i2c_busy) begin
                        if (k == 2'd2) begin
                            write_count <= write_count + 1'b1;
                            cnt         <= GAP_LD;
                            state       <= S_GAP;
                        end else begin
                            k        <= k + 1'b1;
                            i2c_data <= (k == 2'd0) ? reg_b : val_b;
                            i2c_last <= (k == 2'd1);
                            state    <= S_SEND;
                        end
                    end else if (cnt == TO_LAST) begin
                        state <= S_ERROR;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_GAP, S_DELAY: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else if (tbl_addr == ADDR_LAST) begin
                        state <= S_DONE;
                    end else begin
                        tbl_addr <= tbl_addr + 1'b1;
                        state    <= S_FETCH;
                    end
                end
                S_DONE, S_ERROR: begin
                    if (start) begin
                        tbl_addr    <= '0;
                        write_count <= '0;
                        state       <= S_FETCH;
                    end
                end
                default: state <= S_POWERUP;
            endcase
        end
    end

endmodule

// File: doc/ov7670_config_seq.md
# ov7670_config_seq

Table-driven configuration sequencer for the OV7670 SCCB port. After reset it waits out the camera power-up time. It then walks a register table and issues each (register, value) entry as a 3-byte SCCB write through the shared byte-level I2C engine, using that engine's strobe/busy/last handshake. It sits between the camera-parameter ROM and the I2C engine, replacing ad-hoc init logic in the camera controller, and reports done/error to the capture path.

## Interface
- POWERUP_TICKS, 6000000: cycles waited after reset before the first write (120 ms at 50 MHz).
- GAP_TICKS, 10: idle cycles between consecutive 3-byte writes.
- TIMEOUT_TICKS, 50000: maximum consecutive cycles i2c_busy may stay high before the block flags an error.
- DELAY_UNIT, 50000: cycles per unit for delay entries (1 ms at 50 MHz).
- ADDR_W, 6: table address width; the table holds 2^ADDR_W entries.
- SLAVE_WADDR, 8'h42: SCCB write address byte.
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high.
- start  in  1  single-cycle pulse; re-runs the table from entry 0 when in DONE or ERROR; ignored otherwise.
- tbl_addr  out  ADDR_W  table address, registered.
- tbl_data  in  16  combinational ROM data for tbl_addr; [15:8] register, [7:0] value.
- i2c_strobe  out  1  one-cycle byte request to the engine.
- i2c_data  out  8  byte to send; valid while i2c_strobe is high and held until the next strobe.
- i2c_last  out  1  marks the final byte of a transfer; qualified by i2c_strobe.
- i2c_busy  in  1  engine is transferring.
- cfg_busy  out  1  sequence in progress.
- cfg_done  out  1  table completed; level.
- cfg_error  out  1  engine timeout; level.
- write_count  out  ADDR_W+1  number of completed 3-byte writes.

## Operation
- Table entry codes:
  - 16'hFFFF is the end marker.
  - Register byte 8'hF0 with any other value is a delay entry: wait value×DELAY_UNIT cycles. Value 0 means no wait.
  - Every other entry is a write.
- States: POWERUP, FETCH, SEND, WAIT, GAP, DELAY, DONE, ERROR.
- POWERUP:
  - Entered on reset.
  - Down-counter loads POWERUP_TICKS; the block goes to FETCH when the counter reaches 0.
- FETCH (1 cycle): samples tbl_data.
  - End marker → DONE.
  - Delay entry → DELAY.
  - Otherwise latch register/value, set byte index k=0, i2c_data=SLAVE_WADDR → SEND.
- SEND (1 cycle): i2c_strobe=1, i2c_last=(k==2) → WAIT.
- WAIT:
  - The first cycle is a guard; i2c_busy is ignored.
  - After the guard, when i2c_busy=0:
    - k<2: k+1; load i2c_data (k=1 register, k=2 value) → SEND.
    - k=2: increment write_count → GAP.
  - The timeout counter counts consecutive busy-high cycles. Reaching TIMEOUT_TICKS → ERROR.
- GAP: wait GAP_TICKS cycles, then advance tbl_addr → FETCH.
- DELAY: wait value×DELAY_UNIT cycles (0 → leave after 1 cycle), then advance tbl_addr → FETCH. Delay entries do not increment write_count.
- Address wrap: completing the entry at tbl_addr=2^ADDR_W−1 goes → DONE, not back to entry 0.
- DONE / ERROR: hold. On start:
  - tbl_addr=0, write_count=0, cfg_done=0, cfg_error=0 → FETCH.
  - POWERUP is skipped.
- start is ignored in every other state, including the cycle it coincides with a DONE transition. It takes effect only once the block is already in DONE.
- Reset mid-transfer abandons the transfer immediately. All state returns to reset values. The engine's own reset covers the bus.
- Delay counter width must hold 255×DELAY_UNIT without overflow.

## Timing
- Reset values:
  - state=POWERUP, tbl_addr=0, i2c_strobe=0, i2c_data=8'h00, i2c_last=0, write_count=0.
  - cfg_busy=1, cfg_done=0, cfg_error=0.
- i2c_strobe is a Moore decode of registered state, high exactly in SEND.
- i2c_data and i2c_last are registered and change only on entry to SEND.
- First i2c_strobe: high in the cycle after rising edge POWERUP_TICKS+2 following reset deassertion.
- Per-byte spacing: strobe → earliest next strobe = 3 cycles (SEND, guard, one idle-busy WAIT cycle). Longer if the engine holds busy.
- cfg_busy = state not in {DONE, ERROR}.
- cfg_done / cfg_error assert on the edge entering DONE / ERROR.

## Test plan
- POWERUP_TICKS=20, GAP_TICKS=4, table {12:80, 40:D0, FFFF}, engine model busy for 6 cycles per byte → six strobes carrying bytes 42,12,80,42,40,D0; i2c_last high on the 3rd and 6th; first strobe after edge 22; cfg_done=1, write_count=2.
- Table {F0:03, 11:01, FFFF}, DELAY_UNIT=8 → no strobe for 24 cycles after FETCH of entry 0; then bytes 42,11,01; write_count=1.
- Engine holds busy high forever on byte 2, TIMEOUT_TICKS=100 → cfg_error=1 exactly 100 busy cycles after the guard; cfg_busy=0; no further strobes. A start pulse then replays from entry 0.
- ADDR_W=2, table of 4 writes with no end marker → 12 strobes, DONE after entry 3, tbl_addr never returns to 0 before DONE.
- Reset asserted during WAIT of byte 2 → i2c_strobe=0 and write_count=0 immediately; sequence restarts with full POWERUP.
- start pulsed during POWERUP and during WAIT → ignored; byte stream identical to run without start.
